vga_pixel_out: RTL
==================

Name: vga_pixel_out

Overview:
Downstream stage of the 800x600@60 Hz VGA timing generator, on the same 40 MHz pixel_clk. Consumes the timing generator's h_sync, v_sync, visible flag and pixel coordinates, and selects a colour source: external 3-3-2 colour or one of three built-in test patterns. Expands the selected colour to 8-bit RGB, blanks it outside the visible area, and delays sync and data-enable by the same latency so they stay aligned at the DAC/monitor pins.

Parameters:
H_VISIBLE, 800, visible pixels per line
V_VISIBLE, 600, visible lines per frame
BAR_WIDTH, 16, width in pixels of the moving-bar pattern
BAR_STEP, 4, moving-bar advance in pixels per frame
CHECK_LOG2, 5, checkerboard square size is 2**CHECK_LOG2 pixels

Ports:
pixel_clk  in  1  pixel clock, 40 MHz
reset  in  1  asynchronous, active-low reset
h_sync_in  in  1  horizontal sync from timing generator, low during pulse
v_sync_in  in  1  vertical sync from timing generator, low during pulse
de_in  in  1  high when the current pixel is in the visible area
x_in  in  10  current pixel column, valid when de_in=1
y_in  in  10  current pixel row, valid when de_in=1
colour_in  in  8  external colour {R[2:0],G[2:0],B[1:0]}
pattern_sel  in  2  source select: 0 external, 1 colour bars, 2 checkerboard, 3 moving bar
red  out  8  red intensity
green  out  8  green intensity
blue  out  8  blue intensity
h_sync  out  1  h_sync_in delayed 2 cycles
v_sync  out  1  v_sync_in delayed 2 cycles
de  out  1  de_in delayed 2 cycles
frame_start  out  1  one-cycle pulse coincident with v_sync output falling edge
frame_count  out  16  frames since reset, wraps at 65535 to 0

Behaviour:
- Reset: asynchronous, active-low. While reset=0 and after release, all outputs hold these values until the pipeline fills:
  - red, green, blue = 0
  - h_sync = 1, v_sync = 1
  - de = 0, frame_start = 0, frame_count = 0
  - internal: active_pattern = 0, bar_pos = 0, both pipeline stages cleared to the same idle values.
- Pipeline: fixed 2-cycle latency from inputs to all outputs. The {RGB, h_sync, v_sync, de} output set always comes from the same input cycle.
  - Stage 1 registers the sync signals, de, x, y and colour_in.
  - Stage 1 also computes the pattern colour in 3-3-2 form.
  - Stage 2 expands the colour, applies blanking and registers the outputs.
- Frame edge:
  - vs_fall = v_sync_in==0 while the previous registered v_sync_in==1.
  - On vs_fall:
    - active_pattern <= pattern_sel;
    - frame_count <= frame_count+1;
    - bar_pos <= (bar_pos+BAR_STEP > H_VISIBLE-BAR_WIDTH) ? 0 : bar_pos+BAR_STEP.
  - pattern_sel changes between edges are ignored (no tearing).
  - frame_start goes high for exactly 1 cycle, in the same cycle the v_sync output first goes 0.
- Patterns, all 3-3-2, computed from the stage-1 x and y:
  - 0 external: colour_in.
  - 1 colour bars: 8 bars of H_VISIBLE/8 = 100 pixels each, decided with comparators, no divider. Order from x=0: white FF, yellow FC, cyan 1F, green 1C, magenta E3, red E0, blue 03, black 00.
  - 2 checkerboard: FF if x[CHECK_LOG2]^y[CHECK_LOG2], else 00.
  - 3 moving bar: FF if bar_pos <= x < bar_pos+BAR_WIDTH, else 00. The bar occupies all rows.
- Expansion is bit replication, so full scale = 8'hFF:
  - red = {R,R,R[2:1]}
  - green = {G,G,G[2:1]}
  - blue = {B,B,B,B}
- Blanking: if the stage-2 de = 0, then red = green = blue = 0, whatever the pattern.
- Widths: x/y comparisons are 11-bit unsigned so that bar_pos+BAR_WIDTH cannot overflow. frame_count wraps modulo 2^16.
- Simultaneous events: if vs_fall coincides with a pattern_sel change, the new value is latched. A frame edge never alters pixels already in stage 1 or stage 2.
- Reset mid-frame: all state clears immediately. The next vs_fall after release is counted as frame 1.

Decomposition:
- Shared package vga_pkg holds:
  - timing constants H_VISIBLE and V_VISIBLE;
  - the pattern_sel encodings PAT_EXT, PAT_BARS, PAT_CHECK, PAT_BAR;
  - the 8 colour-bar 3-3-2 constants.
- The timing generator also imports vga_pkg.
- One natural sub-module: vga_colour_expand, a combinational 3-3-2 to 8-8-8 expander with blanking, instantiated in stage 2.

Test Plan:
- Reset: hold reset=0 for 5 cycles with random inputs -> RGB=0, h_sync=v_sync=1, de=0, frame_count=0; release, drive idle inputs for 2 cycles -> outputs unchanged.
- Latency/alignment: pattern 0, colour_in=8'hE0, de_in=1 for one cycle at cycle N -> red=FF, green=00, blue=00, de=1 only at N+2; h_sync_in toggle at N -> h_sync toggles at N+2.
- Colour bars: after a vs_fall with pattern_sel=1, sweep x=0..799 with y=10 -> x=0..99 gives FFFFFF; x=100 gives FFFF00 (yellow); x=599 gives FF0000; x=700..799 gives 000000.
- Checkerboard: pattern 2 -> (x,y)=(0,0) gives 000000, (32,0) gives FFFFFF, (32,32) gives 000000.
- Moving bar and frame edge: 3 vs_fall edges with pattern_sel=3 -> frame_count=3, bar_pos=12, x=11 black, x=12..27 white, x=28 black; frame_start high exactly 1 cycle per edge, aligned to v_sync output falling. Step bar_pos to 784 -> next edge wraps it to 0.
- Blanking and mid-frame select: de_in=0 with colour_in=FF -> RGB=0; change pattern_sel mid-frame -> output pattern unchanged until the next vs_fall.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA constants, pattern encodings and colour-bar lookup
package vga_pkg;

    localparam int H_VISIBLE = 800;
    localparam int V_VISIBLE = 600;
    localparam int BAR_SPAN  = H_VISIBLE / 8;

    typedef enum logic [1:0] {
        PAT_EXT   = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_BAR   = 2'd3
    } pattern_e;

    localparam logic [7:0] COL_WHITE   = 8'hFF;
    localparam logic [7:0] COL_YELLOW  = 8'hFC;
    localparam logic [7:0] COL_CYAN    = 8'h1F;
    localparam logic [7:0] COL_GREEN   = 8'h1C;
    localparam logic [7:0] COL_MAGENTA = 8'hE3;
    localparam logic [7:0] COL_RED     = 8'hE0;
    localparam logic [7:0] COL_BLUE    = 8'h03;
    localparam logic [7:0] COL_BLACK   = 8'h00;

    // Comparator chain instead of x / BAR_SPAN keeps a divider out of the pixel path.
    function automatic logic [7:0] colour_bar(input logic [10:0] x);
        if      (x < 11'(1 * BAR_SPAN)) return COL_WHITE;
        else if (x < 11'(2 * BAR_SPAN)) return COL_YELLOW;
        else if (x < 11'(3 * BAR_SPAN)) return COL_CYAN;
        else if (x < 11'(4 * BAR_SPAN)) return COL_GREEN;
        else if (x < 11'(5 * BAR_SPAN)) return COL_MAGENTA;
        else if (x < 11'(6 * BAR_SPAN)) return COL_RED;
        else if (x < 11'(7 * BAR_SPAN)) return COL_BLUE;
        else                            return COL_BLACK;
    endfunction

endpackage

// File: rtl/vga_colour_expand.sv
// rtl/vga_colour_expand.sv - 3-3-2 to 8-8-8 bit-replication expander with blanking
module vga_colour_expand (
    input  logic [7:0] colour,
    input  logic       de,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue
);

    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;

    always_comb begin
        r = colour[7:5];
        g = colour[4:2];
        b = colour[1:0];
        red   = 8'h00;
        green = 8'h00;
        blue  = 8'h00;
        if (de) begin
            red   = {r, r, r[2:1]};
            green = {g, g, g[2:1]};
            blue  = {b, b, b, b};
        end
    end

endmodule

// File: rtl/vga_pixel_out.sv
// rtl/vga_pixel_out.sv - two-stage VGA pixel output with test patterns and aligned sync
module vga_pixel_out
    import vga_pkg::*;
#(
    parameter int BAR_WIDTH  = 16,
    parameter int BAR_STEP   = 4,
    parameter int CHECK_LOG2 = 5
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic        de_in,
    input  logic [9:0]  x_in,
    input  logic [9:0]  y_in,
    input  logic [7:0]  colour_in,
    input  logic [1:0]  pattern_sel,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        h_sync,
    output logic        v_sync,
    output logic        de,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    logic        hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d, ychk1_q, ychk1_d;
    logic [9:0]  x1_q, x1_d;
    logic [7:0]  col1_q, col1_d;
    logic        hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d;
    logic [7:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic        frame_start_q, frame_start_d;
    logic [15:0] frame_count_q, frame_count_d;
    pattern_e    active_pattern_q, active_pattern_d;
    logic [10:0] bar_pos_q, bar_pos_d;

    logic        vs_fall;
    logic [10:0] bar_next, bar_end, x_ext;
    logic [7:0]  pat_colour;
    logic [7:0]  exp_red, exp_green, exp_blue;

    // Stage 1 capture, frame-edge state and 3-3-2 pattern selection.
    always_comb begin
        vs_fall          = ~v_sync_in & vs1_q;
        hs1_d            = h_sync_in;
        vs1_d            = v_sync_in;
        de1_d            = de_in;
        x1_d             = x_in;
        ychk1_d          = y_in[CHECK_LOG2];
        col1_d           = colour_in;
        active_pattern_d = active_pattern_q;
        frame_count_d    = frame_count_q;
        bar_pos_d        = bar_pos_q;
        bar_next         = bar_pos_q + 11'(BAR_STEP);
        if (vs_fall) begin
            active_pattern_d = pattern_e'(pattern_sel);
            frame_count_d    = frame_count_q + 16'd1;
            bar_pos_d        = (bar_next > 11'(H_VISIBLE - BAR_WIDTH)) ? 11'd0 : bar_next;
        end
        x_ext   = {1'b0, x1_q};
        bar_end = bar_pos_q + 11'(BAR_WIDTH);
        case (active_pattern_q)
            PAT_EXT:   pat_colour = col1_q;
            PAT_BARS:  pat_colour = colour_bar(x_ext);
            PAT_CHECK: pat_colour = (x1_q[CHECK_LOG2] ^ ychk1_q) ? COL_WHITE : COL_BLACK;
            default:   pat_colour = (x_ext >= bar_pos_q && x_ext < bar_end) ? COL_WHITE : COL_BLACK;
        endcase
    end

    vga_colour_expand u_expand (
        .colour (pat_colour),
        .de     (de1_q),
        .red    (exp_red),
        .green  (exp_green),
        .blue   (exp_blue)
    );

    // Stage 2: frame_start marks the cycle where v_sync output first drops.
    always_comb begin
        hs2_d         = hs1_q;
        vs2_d         = vs1_q;
        de2_d         = de1_q;
        frame_start_d = ~vs1_q & vs2_q;
        red_d         = exp_red;
        green_d       = exp_green;
        blue_d        = exp_blue;
    end

    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            hs1_q            <= 1'b1;
            vs1_q            <= 1'b1;
            de1_q            <= 1'b0;
            ychk1_q          <= 1'b0;
            x1_q             <= 10'd0;
            col1_q           <= 8'h00;
            hs2_q            <= 1'b1;
            vs2_q            <= 1'b1;
            de2_q            <= 1'b0;
            red_q            <= 8'h00;
            green_q          <= 8'h00;
            blue_q           <= 8'h00;
            frame_start_q    <= 1'b0;
            frame_count_q    <= 16'd0;
            active_pattern_q <= PAT_EXT;
            bar_pos_q        <= 11'd0;
        end else begin
            hs1_q            <= hs1_d;
            vs1_q            <= vs1_d;
            de1_q            <= de1_d;
            ychk1_q          <= ychk1_d;
            x1_q             <= x1_d;
            col1_q           <= col1_d;
            hs2_q            <= hs2_d;
            vs2_q            <= vs2_d;
            de2_q            <= de2_d;
            red_q            <= red_d;
            green_q          <= green_d;
            blue_q           <= blue_d;
            frame_start_q    <= frame_start_d;
            frame_count_q    <= frame_count_d;
            active_pattern_q <= active_pattern_d;
            bar_pos_q        <= bar_pos_d;
        end
    end

    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign h_sync      = hs2_q;
    assign v_sync      = vs2_q;
    assign de          = de2_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule
